tilemap_column_writer: RTL and testbench
========================================

Name: tilemap_column_writer

Overview:
- Avalon-MM host that drives the tile display peripheral's 8-bit agent port.
- Per command, it streams one column of tile numbers into the tilemap, then optionally writes the 10-bit scroll offset. This supports horizontal-scroll level rendering: software or the level engine pushes the next column while the display scrolls.
- Sits between the level-streaming logic (command + byte stream) and the tile peripheral's agent port in the same clock domain.

Parameters:
- ROWS, 30, tiles per column written per command (1..32).
- STRIDE_LOG2, 7, log2 of tilemap row stride in bytes (128 columns).
- TM_BASE, 15'h0000, tilemap base byte address.
- SCROLL_ADDR, 15'h3000, scroll-offset low-byte address; high byte is SCROLL_ADDR+1.

Ports:
- clk  in  1  system clock, shared with the agent.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_col  in  STRIDE_LOG2  target tilemap column.
- cmd_scroll  in  10  scroll offset written after the column.
- cmd_scroll_en  in  1  1 = write scroll offset after the column.
- td_valid  in  1  tile byte available.
- td_ready  out  1  tile byte accepted this cycle when td_valid && td_ready.
- td_data  in  8  tile number, row 0 first.
- m_address  out  15  Avalon address.
- m_chipselect  out  1  Avalon chipselect.
- m_write  out  1  Avalon write strobe.
- m_writedata  out  8  Avalon write data.
- m_waitrequest  in  1  agent stall; tie 0 for the tile peripheral.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, row=0, pending=0.
  - m_chipselect=0, m_write=0, m_address=0, m_writedata=0, td_ready=0, done=0, busy=0, cmd_ready=1.
  - Reset asserted mid-command aborts immediately; a partial column stays in the tilemap, and no scroll write occurs.
- Avalon host rules:
  - A write is issued by m_chipselect=m_write=1 with address and data valid.
  - Accepted on the first rising edge with m_waitrequest=0.
  - While m_waitrequest=1, address, data and strobes hold stable.
  - Never reads; m_chipselect=0 when no write is pending.
- States: IDLE, COL, SCRL_LO, SCRL_HI, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch col, scroll and scroll_en; row<=0; go to COL.
- COL:
  - td_ready = (!pending || accept) && (rows_loaded < ROWS), where accept = pending && !m_waitrequest.
  - On a td handshake, load m_writedata=td_data and m_address = TM_BASE + (row_load << STRIDE_LOG2) + col; set pending.
  - Each accept increments the rows_written count.
  - Back-to-back loads are allowed, giving 1 byte/cycle when waitrequest=0 and td_valid stays high.
  - When rows_written reaches ROWS: go to SCRL_LO if scroll_en, else DONE.
  - td_valid low simply stalls with pending=0. There is no timeout.
- SCRL_LO: write SCROLL_ADDR with data scroll[7:0]; on accept, go to SCRL_HI.
- SCRL_HI: write SCROLL_ADDR+1 with data {6'b0, scroll[9:8]}; on accept, go to DONE.
  - Low byte is always written before high byte.
- DONE: done=1 for one cycle, then IDLE. cmd_ready=0 in DONE, so there is at most one command per DONE pulse.
- Address arithmetic is 15-bit, and all addresses stay below 15'h1000 for defaults: max 29*128+127 = 3839.
- Elaboration assertion: TM_BASE + ((ROWS-1)<<STRIDE_LOG2) + 2^STRIDE_LOG2 - 1 < 15'h1000.
- Latency with waitrequest=0 and data ready:
  - cmd handshake to first write strobe: 2 cycles.
  - ROWS consecutive write cycles.
  - With scroll enabled, done follows the last tile write by 3 cycles.
- Simultaneous events: a td handshake in the same cycle as an accept replaces the pending beat with no gap. cmd_valid outside IDLE is ignored (cmd_ready=0).

Decomposition:
- Package tile_bus_pkg holds the shared memory-map constants: TM_BASE, PALETTE_BASE=15'h2000, SCROLL_ADDR=15'h3000, TILESET_BASE=15'h4000.
- tile_bus_pkg also holds the state enum typedef tcw_state_t, for reuse by future palette and tileset loaders.
- One natural sub-module: avalon_wr_host, a single-beat write holding register that implements the pending/hold/accept handshake. The FSM feeds it.

Test Plan:
- Basic column: cmd_col=5, scroll_en=0, ROWS=30, bytes 0x10..0x2D, waitrequest=0 -> 30 writes to addresses 5, 133, ..., 3717 with matching data on consecutive cycles; done pulses once; no write to 0x3000.
- Scroll update: cmd_col=127, cmd_scroll=10'h2A5, scroll_en=1 -> last tile at address 3839, then 0x3000<=0xA5, then 0x3001<=0x02, then done.
- Waitrequest stall: hold m_waitrequest=1 for 3 cycles on row 7 -> address, data and strobes stable for 4 cycles; td_ready=0 during the stall; no byte lost or duplicated.
- Bubbly stream: td_valid toggles 1,0,0,1... -> m_chipselect drops during gaps; all 30 bytes written in order; busy stays high.
- Reset mid-op: drop reset_n at row 12 -> all outputs immediately at reset values; a next command with col=0 writes rows 0..29 correctly.
- Back-pressure on commands: cmd_valid held high through completion -> second command is accepted only after the done cycle, when IDLE is re-entered.

Source files
------------

// File: rtl/tile_bus_pkg.sv
// Shared memory map of the tile display peripheral and the loader state type
// reused by the column writer and future palette/tileset loaders.
package tile_bus_pkg;

    localparam logic [14:0] TM_BASE      = 15'h0000;
    localparam logic [14:0] PALETTE_BASE = 15'h2000;
    localparam logic [14:0] SCROLL_ADDR  = 15'h3000;
    localparam logic [14:0] TILESET_BASE = 15'h4000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COL     = 3'd1,
        ST_SCRL_LO = 3'd2,
        ST_SCRL_HI = 3'd3,
        ST_DONE    = 3'd4
    } tcw_state_t;

endpackage

// File: rtl/avalon_wr_host.sv
// Single-beat Avalon-MM write holding register: a loaded beat is presented
// until the agent accepts it, and a new beat may replace it in the accept cycle.
module avalon_wr_host #(
    parameter int AW = 15,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [AW-1:0] load_address,
    input  logic [DW-1:0] load_data,
    input  logic          m_waitrequest,
    output logic [AW-1:0] m_address,
    output logic          m_chipselect,
    output logic          m_write,
    output logic [DW-1:0] m_writedata,
    output logic          pending,
    output logic          accept
);

    logic          pending_reg;
    logic [AW-1:0] address_reg;
    logic [DW-1:0] data_reg;
    logic          load_ok;

    assign accept  = pending_reg && !m_waitrequest;
    // A stalled beat is never overwritten, whatever the feeder asks for.
    assign load_ok = load && (!pending_reg || accept);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= 1'b0;
            address_reg <= '0;
            data_reg    <= '0;
        end else if (load_ok) begin
            pending_reg <= 1'b1;
            address_reg <= load_address;
            data_reg    <= load_data;
        end else if (accept) begin
            pending_reg <= 1'b0;
        end
    end

    assign m_address    = address_reg;
    assign m_writedata  = data_reg;
    assign m_chipselect = pending_reg;
    assign m_write      = pending_reg;
    assign pending      = pending_reg;

endmodule

// File: rtl/tilemap_column_writer.sv
// Streams one column of tile numbers into the tilemap per command, then
// optionally writes the 10-bit horizontal scroll offset (low byte first).
module tilemap_column_writer #(
    parameter int          ROWS        = 30,
    parameter int          STRIDE_LOG2 = 7,
    parameter logic [14:0] TM_BASE     = tile_bus_pkg::TM_BASE,
    parameter logic [14:0] SCROLL_ADDR = tile_bus_pkg::SCROLL_ADDR
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [STRIDE_LOG2-1:0] cmd_col,
    input  logic [9:0]             cmd_scroll,
    input  logic                   cmd_scroll_en,
    input  logic                   td_valid,
    output logic                   td_ready,
    input  logic [7:0]             td_data,
    output logic [14:0]            m_address,
    output logic                   m_chipselect,
    output logic                   m_write,
    output logic [7:0]             m_writedata,
    input  logic                   m_waitrequest,
    output logic                   busy,
    output logic                   done
);
    import tile_bus_pkg::*;

    localparam logic [5:0] ROWS_C = 6'(ROWS);
    localparam int LAST_TILE = int'(TM_BASE) + ((ROWS - 1) << STRIDE_LOG2) + (1 << STRIDE_LOG2) - 1;

    generate
        if (ROWS < 1 || ROWS > 32 || LAST_TILE >= 'h1000) begin : g_bad_map
            $error("tilemap column does not fit below 15'h1000");
        end
    endgenerate

    tcw_state_t             state_reg, state_next;
    logic [STRIDE_LOG2-1:0] col_reg;
    logic [9:0]             scroll_reg;
    logic                   scroll_en_reg;
    logic [5:0]             rows_loaded_reg;
    logic [5:0]             rows_written_reg;

    logic        pending, accept, load;
    logic [14:0] load_address;
    logic [7:0]  load_data;
    logic [14:0] tile_address;
    logic        td_fire, last_row;

    assign td_fire      = td_valid && td_ready;
    assign last_row     = accept && (rows_written_reg == ROWS_C - 6'd1);
    assign tile_address = TM_BASE + (15'(rows_loaded_reg) << STRIDE_LOG2) + 15'(col_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (cmd_valid) state_next = ST_COL;
            ST_COL:     if (last_row) state_next = scroll_en_reg ? ST_SCRL_LO : ST_DONE;
            ST_SCRL_LO: if (accept) state_next = ST_SCRL_HI;
            ST_SCRL_HI: if (accept) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // The scroll low byte is loaded in the same cycle the last tile is accepted,
    // so the three closing writes run back to back.
    always_comb begin
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        td_ready     = 1'b0;
        load         = 1'b0;
        load_address = tile_address;
        load_data    = td_data;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_COL: begin
                td_ready = (!pending || accept) && (rows_loaded_reg < ROWS_C);
                load     = td_valid && td_ready;
                if (last_row && scroll_en_reg) begin
                    load         = 1'b1;
                    load_address = SCROLL_ADDR;
                    load_data    = scroll_reg[7:0];
                end
            end
            ST_SCRL_LO: begin
                if (accept) begin
                    load         = 1'b1;
                    load_address = SCROLL_ADDR + 15'd1;
                    load_data    = {6'b0, scroll_reg[9:8]};
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_reg          <= '0;
            scroll_reg       <= '0;
            scroll_en_reg    <= 1'b0;
            rows_loaded_reg  <= '0;
            rows_written_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (cmd_valid) begin
                col_reg          <= cmd_col;
                scroll_reg       <= cmd_scroll;
                scroll_en_reg    <= cmd_scroll_en;
                rows_loaded_reg  <= '0;
                rows_written_reg <= '0;
            end
        end else if (state_reg == ST_COL) begin
            if (td_fire) rows_loaded_reg <= rows_loaded_reg + 6'd1;
            if (accept)  rows_written_reg <= rows_written_reg + 6'd1;
        end
    end

    avalon_wr_host #(
        .AW(15),
        .DW(8)
    ) u_host (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .load_address (load_address),
        .load_data    (load_data),
        .m_waitrequest(m_waitrequest),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .pending      (pending),
        .accept       (accept)
    );

endmodule

// File: tb/tb_tilemap_column_writer.sv
// Scoreboard bench: the reference model lists every expected Avalon write and
// done pulse per command; a negedge monitor pops and compares them.
module tb_tilemap_column_writer;

    localparam int ROWS   = 30;
    localparam int STRIDE = 128;
    localparam int SCROLL = 'h3000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_col = '0;
    logic [9:0]  cmd_scroll = '0;
    logic        cmd_scroll_en = 1'b0;
    logic        td_valid = 1'b0;
    logic        td_ready;
    logic [7:0]  td_data = '0;
    logic [14:0] m_address;
    logic        m_chipselect;
    logic        m_write;
    logic [7:0]  m_writedata;
    logic        m_waitrequest = 1'b0;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    tilemap_column_writer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_col      (cmd_col),
        .cmd_scroll   (cmd_scroll),
        .cmd_scroll_en(cmd_scroll_en),
        .td_valid     (td_valid),
        .td_ready     (td_ready),
        .td_data      (td_data),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_waitrequest(m_waitrequest),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        bit is_done;
        int addr;
        int data;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         hs_cyc = 0;
    int         last_tile_cyc = 0;
    int         stall_cnt = 0;
    bit         wr_rand = 0;
    bit         lat_check = 1;
    bit         consec_check = 0;
    bit         scroll_lat_check = 0;
    bit         await_first = 0;
    bit         first_in_cmd = 0;
    logic [7:0] tile_bytes[ROWS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic give_up(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Reference model: one column of tiles down the tilemap, then scroll bytes, then done.
    task automatic expect_cmd(input int col, input int scroll, input bit en, input int nrows);
        for (int r = 0; r < nrows; r++)
            exp_q.push_back('{0, r * STRIDE + col, int'(tile_bytes[r])});
        if (nrows == ROWS) begin
            if (en) begin
                exp_q.push_back('{0, SCROLL, scroll % 256});
                exp_q.push_back('{0, SCROLL + 1, scroll / 256});
            end
            exp_q.push_back('{1, 0, 0});
        end
    endtask

    task automatic start_cmd(input int col, input int scroll, input bit en, input bit keep);
        bit hs;
        int hc;
        cmd_col = 7'(col);
        cmd_scroll = 10'(scroll);
        cmd_scroll_en = en;
        cmd_valid = 1'b1;
        for (int n = 0; ; n++) begin
            if (n > 200) give_up("cmd_handshake");
            @(negedge clk);
            hs = cmd_ready;
            hc = cyc;
            @(posedge clk);
            #1;
            if (hs) break;
        end
        hs_cyc = hc;
        await_first = 1;
        if (!keep) cmd_valid = 1'b0;
        $display("cmd col=%0d scroll=0x%0h en=%0d accepted at cycle %0d", col, scroll, en, hc);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        bit hs;
        for (int g = 0; g < gaps; g++) begin
            td_valid = 1'b0;
            @(negedge clk);
            chk(busy == 1'b1, "busy_in_gap", busy, 1);
            if (g == gaps - 1 && gaps >= 2 && !wr_rand)
                chk(m_chipselect == 1'b0, "cs_drop_in_gap", m_chipselect, 0);
            @(posedge clk);
            #1;
        end
        td_valid = 1'b1;
        td_data = b;
        for (int n = 0; ; n++) begin
            if (n > 200) give_up("td_handshake");
            @(negedge clk);
            hs = td_ready;
            @(posedge clk);
            #1;
            if (hs) break;
        end
    endtask

    task automatic wait_done();
        for (int n = 0; ; n++) begin
            if (n > 500) give_up("done_pulse");
            @(negedge clk);
            if (done) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk(m_chipselect == 1'b0, "rst_chipselect", m_chipselect, 0);
        chk(m_write == 1'b0, "rst_write", m_write, 0);
        chk(m_address == 15'd0, "rst_address", m_address, 0);
        chk(m_writedata == 8'd0, "rst_writedata", m_writedata, 0);
        chk(td_ready == 1'b0, "rst_td_ready", td_ready, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(cmd_ready == 1'b1, "rst_cmd_ready", cmd_ready, 1);
    endtask

    task automatic run_column(input int col, input int scroll, input bit en, input int gap_max);
        expect_cmd(col, scroll, en, ROWS);
        start_cmd(col, scroll, en, 0);
        for (int r = 0; r < ROWS; r++)
            send_byte(tile_bytes[r], (r == 0) ? 0 : $urandom_range(0, gap_max));
        td_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall_cnt > 0) begin
                m_waitrequest = 1'b1;
                stall_cnt--;
            end else begin
                m_waitrequest = wr_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    // Monitor: every accepted write and every done pulse pops one expectation.
    initial begin
        bit   prev_stall = 0;
        int   prev_addr = 0;
        int   prev_data = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 0;
                continue;
            end
            chk(cmd_ready == !busy, "cmd_ready_vs_busy", cmd_ready, !busy);
            if (prev_stall)
                chk(m_chipselect && m_write && m_address == 15'(prev_addr) && m_writedata == 8'(prev_data),
                    "hold_stable", int'(m_address) * 256 + int'(m_writedata), prev_addr * 256 + prev_data);
            if (m_chipselect && m_waitrequest)
                chk(td_ready == 1'b0, "td_ready_in_stall", td_ready, 0);
            if (m_chipselect && await_first) begin
                await_first = 0;
                first_in_cmd = 1;
                if (lat_check) chk(cyc - hs_cyc == 2, "cmd_to_strobe", cyc - hs_cyc, 2);
            end
            if (m_chipselect && m_write && !m_waitrequest) begin
                $display("write addr=0x%04h data=0x%02h cycle %0d", m_address, m_writedata, cyc);
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_write", int'(m_address) * 256 + int'(m_writedata), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk(!e.is_done && m_address == 15'(e.addr) && m_writedata == 8'(e.data), "write",
                        int'(m_address) * 256 + int'(m_writedata), e.is_done ? -1 : e.addr * 256 + e.data);
                end
                if (m_address < 15'h1000) begin
                    if (consec_check && !first_in_cmd)
                        chk(cyc == last_tile_cyc + 1, "consecutive_tiles", cyc - last_tile_cyc, 1);
                    last_tile_cyc = cyc;
                    first_in_cmd = 0;
                end
            end
            if (done) begin
                $display("done pulse cycle %0d", cyc);
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.is_done, "done_order", 1, e.is_done);
                end
                if (scroll_lat_check) chk(cyc - last_tile_cyc == 3, "scroll_done_latency", cyc - last_tile_cyc, 3);
            end
            prev_stall = m_chipselect && m_waitrequest;
            prev_addr = int'(m_address);
            prev_data = int'(m_writedata);
        end
    end

    initial begin
        int col, scroll;
        bit en;

        repeat (3) @(posedge clk);
        #1;
        check_reset();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic column: bytes 0x10.., consecutive writes, no scroll.
        for (int r = 0; r < ROWS; r++) tile_bytes[r] = 8'(16 + r);
        consec_check = 1;
        run_column(5, 0, 0, 0);

        // Scroll update on the last column.
        for (int r = 0; r < ROWS; r++) tile_bytes[r] = 8'($urandom);
        scroll_lat_check = 1;
        run_column(127, 'h2A5, 1, 0);
        scroll_lat_check = 0;
        consec_check = 0;

        // Three-cycle waitrequest stall on row 7.
        for (int r = 0; r < ROWS; r++) tile_bytes[r] = 8'($urandom);
        expect_cmd(33, 'h155, 1, ROWS);
        start_cmd(33, 'h155, 1, 0);
        for (int r = 0; r < ROWS; r++) begin
            send_byte(tile_bytes[r], 0);
            if (r == 7) stall_cnt = 3;
        end
        td_valid = 1'b0;
        wait_done();

        // Bubbly stream: valid pattern 1,0,0,1,...
        for (int r = 0; r < ROWS; r++) tile_bytes[r] = 8'($urandom);
        expect_cmd(64, 'h3FF, 1, ROWS);
        start_cmd(64, 'h3FF, 1, 0);
        for (int r = 0; r < ROWS; r++) send_byte(tile_bytes[r], (r == 0) ? 0 : 2);
        td_valid = 1'b0;
        wait_done();

        // Reset while row 12 is pending: rows 0..11 land, nothing else.
        for (int r = 0; r < ROWS; r++) tile_bytes[r] = 8'($urandom);
        expect_cmd(9, 'h0AA, 1, 12);
        start_cmd(9, 'h0AA, 1, 0);
        for (int r = 0; r <= 12; r++) send_byte(tile_bytes[r], 0);
        reset_n = 1'b0;
        td_valid = 1'b0;
        #1;
        check_reset();
        chk(exp_q.size() == 0, "abort_flush", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int r = 0; r < ROWS; r++) tile_bytes[r] = 8'($urandom);
        run_column(0, 0, 0, 0);

        // cmd_valid held through completion: second command only after done.
        for (int r = 0; r < ROWS; r++) tile_bytes[r] = 8'($urandom);
        expect_cmd(77, 'h123, 1, ROWS);
        start_cmd(77, 'h123, 1, 1);
        for (int r = 0; r < ROWS; r++) send_byte(tile_bytes[r], 0);
        td_valid = 1'b0;
        for (int n = 0; ; n++) begin
            if (n > 500) give_up("done_pulse_bp");
            @(negedge clk);
            if (done) break;
        end
        chk(cmd_ready == 1'b0, "cmd_ready_in_done", cmd_ready, 0);
        @(negedge clk);
        chk(cmd_ready && !busy, "idle_after_done", {cmd_ready, busy}, 2);
        hs_cyc = cyc;
        await_first = 1;
        for (int r = 0; r < ROWS; r++) tile_bytes[r] = 8'($urandom);
        expect_cmd(77, 'h123, 1, ROWS);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int r = 0; r < ROWS; r++) send_byte(tile_bytes[r], 0);
        td_valid = 1'b0;
        wait_done();

        // Random commands with random waitrequest and data gaps.
        lat_check = 0;
        wr_rand = 1;
        for (int k = 0; k < 4; k++) begin
            col = $urandom_range(0, 127);
            scroll = $urandom_range(0, 1023);
            en = 1'($urandom);
            for (int r = 0; r < ROWS; r++) tile_bytes[r] = 8'($urandom);
            run_column(col, scroll, en, 2);
        end
        wr_rand = 0;

        repeat (5) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
